// File: rtl/reaction_pkg.sv
// reaction_pkg: shared definitions for the reaction-time tester.
// Holds the machine_state encodings (also used by the LED driver), the player
// codes, the default timing/seed constants and the LFSR step function.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,  // reserved encoding, never entered
    ST_DELAY   = 3'd2,
    ST_START   = 3'd3,
    ST_STORAGE = 3'd4,
    ST_FOUL    = 3'd5,
    ST_AVERAGE = 3'd6
  } state_t;

  localparam logic PLAYER_A = 1'b1;
  localparam logic PLAYER_B = 1'b0;

  localparam int          RT_MAX     = 9999;
  localparam int          DELAY_BASE = 1000;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  localparam int RT_W   = 14;  // holds 0..9999
  localparam int SUM_W  = 17;  // holds 8 x 9999
  localparam int DLY_W  = 12;  // holds 1000..3047
  localparam int TURN_W = 3;   // trial index 0..7

  // Fibonacci step, taps 16,14,13,11 (1-based) = bits 15,13,12,10.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/reaction_ctrl_if.sv
// reaction_ctrl_if: button/tick inputs and display/LED outputs of the
// reaction controller.
//   master: drives tick_1ms, btn_go, btn_hit, btn_clr, sw_player and
//           observes the status outputs.
//   slave : the controller side (reaction_ctrl).
interface reaction_ctrl_if;
  import reaction_pkg::*;

  logic              tick_1ms;
  logic              btn_go;
  logic              btn_hit;
  logic              btn_clr;
  logic              sw_player;
  logic [2:0]        machine_state;
  logic              cur_player;
  logic [TURN_W-1:0] test_turn_A;
  logic [TURN_W-1:0] test_turn_B;
  logic              stim;
  logic [RT_W-1:0]   result_ms;
  logic              result_valid;
  logic [RT_W-1:0]   avg_ms;
  logic              avg_valid;

  modport master (
    output tick_1ms, btn_go, btn_hit, btn_clr, sw_player,
    input  machine_state, cur_player, test_turn_A, test_turn_B, stim,
           result_ms, result_valid, avg_ms, avg_valid
  );

  modport slave (
    input  tick_1ms, btn_go, btn_hit, btn_clr, sw_player,
    output machine_state, cur_player, test_turn_A, test_turn_B, stim,
           result_ms, result_valid, avg_ms, avg_valid
  );

endinterface

// File: rtl/reaction_ctrl_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, shifting every cycle from reset.
// Ports: clk, rstn (async, active-low) -> rnd (low OUT_W bits of the register).
module lfsr16 #(
  parameter logic [15:0] SEED  = reaction_pkg::LFSR_SEED,  // must be non-zero
  parameter int          OUT_W = 11
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [OUT_W-1:0] rnd
);
  import reaction_pkg::*;

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_reg <= SEED;
    else       lfsr_reg <= lfsr_next(lfsr_reg);
  end

  assign rnd = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: per-player reaction-time test sequencer.
// Arms a random 1000..3047 ms delay, raises the stimulus, counts ms ticks until
// the hit button (saturating at RT_MAX), and keeps eight trials per player with
// a running sum for the average.
// Ports: clk, rstn (async, active-low), bus (reaction_ctrl_if.slave) carrying
// tick/buttons/player switch in and state, turns, stim, result, average out.
module reaction_ctrl #(
  parameter int          RT_MAX     = reaction_pkg::RT_MAX,
  parameter int          DELAY_BASE = reaction_pkg::DELAY_BASE,
  parameter logic [15:0] LFSR_SEED  = reaction_pkg::LFSR_SEED
) (
  input  logic           clk,
  input  logic           rstn,
  reaction_ctrl_if.slave bus
);
  import reaction_pkg::*;

  localparam logic [RT_W-1:0]  RT_SAT   = RT_W'(RT_MAX);
  localparam logic [DLY_W-1:0] DLY_BASE = DLY_W'(DELAY_BASE);

  state_t            state_reg, state_next;
  logic              cur_reg, cur_next;
  logic [TURN_W-1:0] turn_reg [2];
  logic [TURN_W-1:0] turn_next [2];
  logic [SUM_W-1:0]  sum_reg [2];
  logic [SUM_W-1:0]  sum_next [2];
  logic [1:0]        done_reg, done_next;
  logic [DLY_W-1:0]  dly_reg, dly_next;
  logic [RT_W-1:0]   rt_reg, rt_next;
  logic [RT_W-1:0]   result_reg, result_next;
  logic [RT_W-1:0]   avg_reg, avg_next;
  logic              result_valid_reg, result_valid_next;
  logic              avg_valid_reg, avg_valid_next;
  logic              stim_reg, stim_next;
  logic [10:0]       rnd;

  lfsr16 #(.SEED(LFSR_SEED), .OUT_W(11)) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .rnd  (rnd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next        = state_reg;
    cur_next          = cur_reg;
    turn_next         = turn_reg;
    sum_next          = sum_reg;
    done_next         = done_reg;
    dly_next          = dly_reg;
    rt_next           = rt_reg;
    result_next       = result_reg;
    avg_next          = avg_reg;
    result_valid_next = 1'b0;
    avg_valid_next    = 1'b0;
    stim_next         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cur_next = bus.sw_player;
        if (bus.btn_clr) begin
          for (int p = 0; p < 2; p++) begin
            turn_next[p] = '0;
            sum_next[p]  = '0;
          end
          done_next = '0;
          avg_next  = '0;
        end else if (bus.btn_go) begin
          if (done_reg[cur_reg]) begin
            state_next = ST_AVERAGE;
          end else begin
            dly_next   = DLY_BASE + DLY_W'(rnd);
            state_next = ST_DELAY;
          end
        end
      end

      ST_DELAY: begin
        // An early hit wins even on the terminal tick.
        if (bus.btn_hit) begin
          state_next = ST_FOUL;
        end else if (bus.tick_1ms) begin
          dly_next = dly_reg - DLY_W'(1);
          if (dly_reg <= DLY_W'(1)) begin
            dly_next   = '0;
            rt_next    = '0;
            state_next = ST_START;
          end
        end
      end

      ST_START: begin
        // A tick in the same cycle as the hit still counts.
        if (bus.tick_1ms && rt_reg < RT_SAT) rt_next = rt_reg + RT_W'(1);
        if (bus.btn_hit || rt_next >= RT_SAT) state_next = ST_STORAGE;
      end

      ST_STORAGE: begin
        if (bus.btn_go) begin
          if (turn_reg[cur_reg] != '1) begin
            turn_next[cur_reg] = turn_reg[cur_reg] + TURN_W'(1);
            state_next         = ST_IDLE;
          end else begin
            done_next[cur_reg] = 1'b1;
            state_next         = ST_AVERAGE;
          end
        end
      end

      ST_FOUL: begin
        if (bus.btn_go) state_next = ST_IDLE;
      end

      ST_AVERAGE: begin
        if (bus.btn_clr) begin
          for (int p = 0; p < 2; p++) begin
            turn_next[p] = '0;
            sum_next[p]  = '0;
          end
          done_next  = '0;
          avg_next   = '0;
          state_next = ST_IDLE;
        end else if (bus.btn_go) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;  // ARM and the illegal code 7
    endcase

    // Capture on the transition so the result shows in the first STORAGE cycle.
    if (state_next == ST_STORAGE && state_reg != ST_STORAGE) begin
      result_next       = rt_next;
      sum_next[cur_reg] = sum_reg[cur_reg] + SUM_W'(rt_next);
      result_valid_next = 1'b1;
    end

    if (state_next == ST_AVERAGE) begin
      avg_next       = sum_next[cur_next][SUM_W-1:3];
      avg_valid_next = done_next[cur_next];
    end

    stim_next = (state_next == ST_START);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_reg          <= PLAYER_A;
      for (int p = 0; p < 2; p++) begin
        turn_reg[p] <= '0;
        sum_reg[p]  <= '0;
      end
      done_reg         <= '0;
      dly_reg          <= '0;
      rt_reg           <= '0;
      result_reg       <= '0;
      avg_reg          <= '0;
      result_valid_reg <= 1'b0;
      avg_valid_reg    <= 1'b0;
      stim_reg         <= 1'b0;
    end else begin
      cur_reg          <= cur_next;
      turn_reg         <= turn_next;
      sum_reg          <= sum_next;
      done_reg         <= done_next;
      dly_reg          <= dly_next;
      rt_reg           <= rt_next;
      result_reg       <= result_next;
      avg_reg          <= avg_next;
      result_valid_reg <= result_valid_next;
      avg_valid_reg    <= avg_valid_next;
      stim_reg         <= stim_next;
    end
  end

  assign bus.machine_state = state_reg;
  assign bus.cur_player    = cur_reg;
  assign bus.test_turn_A   = turn_reg[PLAYER_A];
  assign bus.test_turn_B   = turn_reg[PLAYER_B];
  assign bus.stim          = stim_reg;
  assign bus.result_ms     = result_reg;
  assign bus.result_valid  = result_valid_reg;
  assign bus.avg_ms        = avg_reg;
  assign bus.avg_valid     = avg_valid_reg;

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: self-checking bench for reaction_ctrl.
// Table-driven eight-trial run plus hand-written sequences for fouls, timeout,
// player switching, clearing and asynchronous reset. Reaction times are pushed
// to a scoreboard queue when the hit is driven and popped on result_valid.
module tb_reaction_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  reaction_ctrl_if bus();

  reaction_ctrl #(
    .RT_MAX     (9999),
    .DELAY_BASE (1000),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int rt;
    int exp_turn;
    int exp_state;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  int          sb_q[$];
  logic [15:0] model_lfsr;
  logic [2:0]  prev_state;

  // Reference LFSR: taps 16,14,13,11, shifting every cycle from the seed.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_lfsr <= 16'hACE1;
    else model_lfsr <= {model_lfsr[14:0],
                        model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: stim tracks START, result pulses pop the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      check("stim_vs_state", bus.stim, bus.machine_state == 3'd3);
      if (bus.result_valid) begin
        check("rv_first_cycle", (bus.machine_state == 3'd4) && (prev_state != 3'd4), 1);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL result_unexpected: got %0d expected none", bus.result_ms);
        end else begin
          check("result_ms", bus.result_ms, sb_q.pop_front());
        end
      end
    end
    prev_state <= bus.machine_state;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    bus.btn_go = 1'b1;
    step();
    bus.btn_go = 1'b0;
  endtask

  task automatic pulse_hit();
    bus.btn_hit = 1'b1;
    step();
    bus.btn_hit = 1'b0;
  endtask

  task automatic wait_start(input int exp_d, input string tag);
    int cnt = 0;
    while (bus.machine_state != 3'd3 && cnt < 4000) begin
      step();
      cnt++;
    end
    check({tag, "_delay_len"}, cnt, exp_d);
  endtask

  task automatic do_trial(input int rt, input string tag);
    int d;
    d = 1000 + int'(model_lfsr[10:0]);
    pulse_go();
    check({tag, "_in_delay"}, bus.machine_state, 2);
    wait_start(d, tag);
    repeat (rt - 1) step();
    sb_q.push_back(rt);
    pulse_hit();
    check({tag, "_stored"}, bus.machine_state, 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   d;

    vecs[0] = '{100, 1, 0};
    vecs[1] = '{200, 2, 0};
    vecs[2] = '{300, 3, 0};
    vecs[3] = '{400, 4, 0};
    vecs[4] = '{500, 5, 0};
    vecs[5] = '{600, 6, 0};
    vecs[6] = '{700, 7, 0};
    vecs[7] = '{800, 7, 6};

    bus.tick_1ms  = 1'b0;
    bus.btn_go    = 1'b0;
    bus.btn_hit   = 1'b0;
    bus.btn_clr   = 1'b0;
    bus.sw_player = 1'b1;
    repeat (3) step();

    check("rst_state", bus.machine_state, 0);
    check("rst_cur", bus.cur_player, 1);
    check("rst_turnA", bus.test_turn_A, 0);
    check("rst_turnB", bus.test_turn_B, 0);
    check("rst_stim", bus.stim, 0);
    check("rst_result", bus.result_ms, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_avg", bus.avg_ms, 0);
    check("rst_avgv", bus.avg_valid, 0);

    rstn = 1'b1;
    bus.tick_1ms = 1'b1;  // one ms per cycle keeps the run short
    step();

    // Single trial for player A.
    do_trial(250, "t250");
    pulse_go();
    check("t250_turnA", bus.test_turn_A, 1);
    check("t250_idle", bus.machine_state, 0);

    // Foul 10 ticks into DELAY.
    pulse_go();
    repeat (10) step();
    check("foul_pre", bus.machine_state, 2);
    pulse_hit();
    check("foul_state", bus.machine_state, 5);
    check("foul_turnA", bus.test_turn_A, 1);
    pulse_go();
    check("foul_exit", bus.machine_state, 0);

    // Hit on the terminal DELAY tick still fouls.
    d = 1000 + int'(model_lfsr[10:0]);
    pulse_go();
    repeat (d - 1) step();
    check("term_pre", bus.machine_state, 2);
    pulse_hit();
    check("term_foul", bus.machine_state, 5);
    pulse_go();
    check("term_exit", bus.machine_state, 0);
    check("term_turnA", bus.test_turn_A, 1);

    // Clear in IDLE.
    bus.btn_clr = 1'b1;
    step();
    bus.btn_clr = 1'b0;
    check("clr_state", bus.machine_state, 0);
    check("clr_turnA", bus.test_turn_A, 0);
    check("clr_avgv", bus.avg_valid, 0);

    // Eight trials for player A.
    for (int i = 0; i < 8; i++) begin
      do_trial(vecs[i].rt, $sformatf("a%0d", i));
      check("turn_hold_storage", bus.test_turn_A, i);
      pulse_go();
      check("turnA_after_ack", bus.test_turn_A, vecs[i].exp_turn);
      check("state_after_ack", bus.machine_state, vecs[i].exp_state);
      check("turnB_zero", bus.test_turn_B, 0);
    end
    check("avg_valid", bus.avg_valid, 1);
    check("avg_ms", bus.avg_ms, 450);

    pulse_go();
    check("avg_exit", bus.machine_state, 0);
    pulse_go();
    check("avg_reenter", bus.machine_state, 6);
    check("avg_reenter_ms", bus.avg_ms, 450);
    check("avg_reenter_v", bus.avg_valid, 1);

    // Go and clear together in AVERAGE: clear wins.
    bus.btn_go  = 1'b1;
    bus.btn_clr = 1'b1;
    step();
    bus.btn_go  = 1'b0;
    bus.btn_clr = 1'b0;
    check("goclr_state", bus.machine_state, 0);
    check("goclr_turnA", bus.test_turn_A, 0);
    check("goclr_avgv", bus.avg_valid, 0);

    // Switch to player B, then toggle the switch during DELAY.
    bus.sw_player = 1'b0;
    step();
    check("sw_to_B", bus.cur_player, 0);
    d = 1000 + int'(model_lfsr[10:0]);
    pulse_go();
    check("b_in_delay", bus.machine_state, 2);
    bus.sw_player = 1'b1;
    step();
    check("cur_hold_delay", bus.cur_player, 0);
    wait_start(d - 1, "b");

    // Timeout: no hit for the full RT_MAX ticks.
    sb_q.push_back(9999);
    repeat (9998) step();
    check("tmo_pre", bus.machine_state, 3);
    step();
    check("tmo_state", bus.machine_state, 4);
    check("tmo_turnB_hold", bus.test_turn_B, 0);
    pulse_go();
    check("tmo_turnB", bus.test_turn_B, 1);
    check("tmo_idle", bus.machine_state, 0);

    // Asynchronous reset in the middle of START.
    d = 1000 + int'(model_lfsr[10:0]);
    pulse_go();
    wait_start(d, "r");
    repeat (37) step();
    check("rmid_pre", bus.machine_state, 3);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("rmid_state", bus.machine_state, 0);
    check("rmid_cur", bus.cur_player, 1);
    check("rmid_turnA", bus.test_turn_A, 0);
    check("rmid_turnB", bus.test_turn_B, 0);
    check("rmid_stim", bus.stim, 0);
    check("rmid_result", bus.result_ms, 0);
    check("rmid_rv", bus.result_valid, 0);
    check("rmid_avg", bus.avg_ms, 0);
    check("rmid_avgv", bus.avg_valid, 0);
    repeat (2) step();
    rstn = 1'b1;
    step();

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
# reaction_ctrl

Main controller of the reaction-time tester: a per-player test sequencer that arms a random delay, presents the stimulus, times the response in milliseconds and keeps eight trials per player. It sits directly upstream of the LED driver, which consumes `machine_state`, `cur_player`, `test_turn_A` and `test_turn_B`. It also feeds result and average values to the numeric display.

## Interface
Parameters:
- `RT_MAX`, 9999: reaction-time saturation value, in ms.
- `DELAY_BASE`, 1000: minimum random delay, in ms.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `tick_1ms` in 1: one-cycle pulse every millisecond.
- `btn_go` in 1: debounced single-cycle pulse that starts, acknowledges or exits.
- `btn_hit` in 1: debounced single-cycle reaction-button pulse.
- `btn_clr` in 1: single-cycle pulse that clears both players' records.
- `sw_player` in 1: player select level; 1 = A, 0 = B.
- `machine_state` out 3: current state encoding.
- `cur_player` out 1: active player; 1 = A, 0 = B.
- `test_turn_A`, `test_turn_B` out 3 each: current trial index (0–7) per player.
- `stim` out 1: stimulus on.
- `result_ms` out 14: last stored reaction time.
- `result_valid` out 1: one-cycle pulse when `result_ms` updates.
- `avg_ms` out 14: average of the current player's eight trials.
- `avg_valid` out 1: `avg_ms` holds a complete eight-trial average.

## Operation
State encodings:
- IDLE=0, ARM=1 (reserved, unused), DELAY=2, START=3, STORAGE=4, FOUL=5, AVERAGE=6.
- Code 7 is illegal and returns to IDLE on the next cycle.

Per-player registers: `turn`[2:0], `sum`[16:0], `done`.

State behaviour:
- IDLE:
  - `cur_player` <= `sw_player` every cycle. `sw_player` is ignored in all other states.
  - `btn_clr` clears `turn`, `sum` and `done` for both players and stays in IDLE.
  - `btn_go` with `done[cur]` set goes to AVERAGE.
  - `btn_go` otherwise loads the delay counter with `DELAY_BASE + lfsr[10:0]` (range 1000–3047 ms) and goes to DELAY.
- DELAY:
  - Counter decrements on each tick.
  - `btn_hit` goes to FOUL.
  - When the counter reaches 0 on a tick, clear the rt counter and go to START.
  - `btn_hit` has priority over the terminal tick in the same cycle.
- START:
  - `stim`=1.
  - rt counter increments on each tick, saturating at `RT_MAX`.
  - `btn_hit` goes to STORAGE.
  - Reaching `RT_MAX` goes to STORAGE, recording 9999.
- STORAGE:
  - First cycle: `result_ms` <= rt, `result_valid`=1, `sum[cur]` += rt.
  - The state then holds, showing the result.
  - On `btn_go` with `turn[cur]` < 7: `turn[cur]`++ and go to IDLE.
  - On `btn_go` with `turn[cur]` == 7: set `done[cur]`, leave `turn` at 7, go to AVERAGE.
- FOUL:
  - The trial is not counted; `turn` and `sum` are unchanged.
  - `btn_go` goes to IDLE.
- AVERAGE:
  - `avg_ms` = `sum[cur]` >> 3.
  - `avg_valid` = `done[cur]`.
  - `btn_go` goes to IDLE.
  - `btn_clr` clears both players and goes to IDLE.
  - `btn_clr` has priority over `btn_go`.

Arithmetic and LFSR:
- `sum` is 17 bits, wide enough for 8 × 9999 with no overflow.
- `avg_ms` truncates.
- The 16-bit Fibonacci LFSR uses taps 16, 14, 13, 11. It shifts every cycle, free-running from reset.

## Timing
- Reset values:
  - `machine_state`=0 (IDLE), `cur_player`=1.
  - turns, sums, done flags, `result_ms`, `avg_ms`, `result_valid`, `avg_valid`, `stim` all 0.
  - LFSR = `LFSR_SEED`.
- All outputs are registered. `machine_state` changes the cycle after the qualifying input pulse.
- `stim` is high exactly while `machine_state`==START.
- `result_valid` is high for one cycle, coincident with the first STORAGE cycle.
- `test_turn` increments in the cycle that leaves STORAGE, never earlier. The trial LED index therefore stays stable through START and STORAGE.
- Measured reaction time equals the number of ticks seen in START, so resolution is ±1 ms.
- `btn_go` is ignored in DELAY and START; `btn_hit` is ignored in IDLE, STORAGE, FOUL and AVERAGE.
- `btn_clr` is honoured only in IDLE and AVERAGE.
- Asserting `rstn` mid-trial aborts the trial and clears everything immediately.

## Structure
- `reaction_pkg` holds the state encodings, `PLAYER_A`=1 and `PLAYER_B`=0, `RT_MAX`, `DELAY_BASE` and `LFSR_SEED`. The LED driver shares the same state constants from this package.
- Sub-module `lfsr16` contains the free-running random source, with a seed parameter.
- Everything else lives in a single FSM plus datapath.

## Test plan
- Player A, one trial: `btn_go`, let DELAY expire, 250 ticks, then `btn_hit`.
  - State goes 2 → 3 → 4; `result_ms`=250 with one `result_valid` pulse.
  - After `btn_go`: `test_turn_A`=1, state 0.
- Foul: `btn_hit` 10 ticks into DELAY.
  - State 5; `turn` unchanged.
  - `btn_go` returns to 0.
  - `btn_hit` on the terminal tick of DELAY also gives 5.
- Eight trials for A at 100, 200, …, 800 ms.
  - After the eighth acknowledgement: state 6, `test_turn_A`=7, `avg_valid`=1, `avg_ms`=450.
  - `test_turn_B`=0 throughout.
- Timeout: no hit in START.
  - After 9999 ticks the state is 4 with `result_ms`=9999.
- Player switch and clear:
  - Toggle `sw_player` in DELAY: `cur_player` holds.
  - In IDLE, `sw_player`=0 makes `cur_player`=0 next cycle.
  - `btn_clr` zeroes both turns and `avg_valid`.
  - Drive `btn_go` and `btn_clr` in the same AVERAGE cycle: the clear wins.
- Reset mid-START:
  - Drop `rstn` at an arbitrary cycle.
  - All outputs are at their reset values before the next clock edge.
